// File: rtl/bnn_pkg.sv
// Shared types and sizing helpers for the binary XNOR-popcount PE array.
package bnn_pkg;

  // Frame controller states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    LOAD_A  = 3'd2,
    COMPUTE = 3'd3,
    OUT     = 3'd4
  } state_t;

  // Row-sum width: enough bits to hold COLS*VEC_W matches without overflow.
  function automatic int psum_width(input int cols, input int vec_w);
    return $clog2(cols * vec_w + 1);
  endfunction

  // Default binarisation threshold: half of the maximum possible row sum, rounded up.
  function automatic int default_thresh(input int cols, input int vec_w);
    return (cols * vec_w + 1) / 2;
  endfunction

endpackage

// File: rtl/bnn_pe_row.sv
// One row of PEs: XNOR of COLS weight/activation words, popcount summed
// across the whole row. Purely combinational.
module bnn_pe_row #(
  parameter int COLS   = 3,
  parameter int VEC_W  = 27,
  parameter int PSUM_W = 7
) (
  input  logic [COLS*VEC_W-1:0] w,
  input  logic [COLS*VEC_W-1:0] a,
  output logic [PSUM_W-1:0]     psum
);

  logic [COLS*VEC_W-1:0] match;

  assign match = ~(w ^ a);

  // Count matching bit positions across all columns of the row.
  always_comb begin
    psum = '0;
    for (int i = 0; i < COLS * VEC_W; i++) begin
      psum = psum + PSUM_W'(match[i]);
    end
  end

endmodule

// File: rtl/bnn_pe_array_ctrl.sv
// Weight-stationary ROWS x COLS binary PE array with frame controller.
// Input handshake: a beat on data_in transfers on a rising edge where
// in_valid && in_ready; in_valid may drop at any time between beats and the
// beat counters simply stall. Output handshake: psum_out/sign_out are held
// with out_valid high until a rising edge with out_ready; the results stay
// on the outputs afterwards until the next COMPUTE phase overwrites them.
module bnn_pe_array_ctrl
  import bnn_pkg::*;
#(
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int VEC_W  = 27,
  parameter int PSUM_W = psum_width(COLS, VEC_W),
  parameter int THRESH = default_thresh(COLS, VEC_W)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VEC_W-1:0]       data_in,
  input  logic                   reload_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROWS*PSUM_W-1:0] psum_out,
  output logic [ROWS-1:0]        sign_out,
  output state_t                 fsm_state
);

  localparam int NW = ROWS * COLS;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t state, state_next;

  logic [CW-1:0]          beat_cnt;
  logic [RW-1:0]          row_cnt;
  logic                   weights_loaded;
  logic [NW*VEC_W-1:0]    w_q;
  logic [COLS*VEC_W-1:0]  a_q;
  logic [ROWS*PSUM_W-1:0] psum_q;
  logic [ROWS-1:0]        sign_q;
  logic [PSUM_W-1:0]      row_sum [ROWS];

  logic accept, reload_eff;
  logic w_we, a_we, psum_we, set_loaded;
  logic beat_inc, beat_clr, row_inc, row_clr;

  assign reload_eff = reload_in || !weights_loaded;
  assign accept     = in_valid && in_ready;

  // Per-row XNOR-popcount units over the resident weights and activations.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    bnn_pe_row #(
      .COLS  (COLS),
      .VEC_W (VEC_W),
      .PSUM_W(PSUM_W)
    ) u_row (
      .w   (w_q[r*COLS*VEC_W +: COLS*VEC_W]),
      .a   (a_q),
      .psum(row_sum[r])
    );
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    w_we       = 1'b0;
    a_we       = 1'b0;
    psum_we    = 1'b0;
    set_loaded = 1'b0;
    beat_inc   = 1'b0;
    beat_clr   = 1'b0;
    row_inc    = 1'b0;
    row_clr    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          if (reload_eff) begin
            w_we = 1'b1;
            if (NW == 1) begin
              set_loaded = 1'b1;
              beat_clr   = 1'b1;
              state_next = LOAD_A;
            end else begin
              beat_inc   = 1'b1;
              state_next = LOAD_W;
            end
          end else begin
            a_we = 1'b1;
            if (COLS == 1) begin
              beat_clr   = 1'b1;
              state_next = COMPUTE;
            end else begin
              beat_inc   = 1'b1;
              state_next = LOAD_A;
            end
          end
        end
      end
      LOAD_W: begin
        in_ready = 1'b1;
        if (accept) begin
          w_we = 1'b1;
          if (beat_cnt == CW'(NW - 1)) begin
            set_loaded = 1'b1;
            beat_clr   = 1'b1;
            state_next = LOAD_A;
          end else begin
            beat_inc = 1'b1;
          end
        end
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (accept) begin
          a_we = 1'b1;
          if (beat_cnt == CW'(COLS - 1)) begin
            beat_clr   = 1'b1;
            state_next = COMPUTE;
          end else begin
            beat_inc = 1'b1;
          end
        end
      end
      COMPUTE: begin
        psum_we = 1'b1;
        if (row_cnt == RW'(ROWS - 1)) begin
          row_clr    = 1'b1;
          state_next = OUT;
        end else begin
          row_inc = 1'b1;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, weight/activation storage and result registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      beat_cnt       <= '0;
      row_cnt        <= '0;
      weights_loaded <= 1'b0;
      w_q            <= '0;
      a_q            <= '0;
      psum_q         <= '0;
      sign_q         <= '0;
    end else begin
      if (beat_clr)      beat_cnt <= '0;
      else if (beat_inc) beat_cnt <= beat_cnt + CW'(1);
      if (row_clr)       row_cnt <= '0;
      else if (row_inc)  row_cnt <= row_cnt + RW'(1);
      if (set_loaded)    weights_loaded <= 1'b1;
      for (int k = 0; k < NW; k++) begin
        if (w_we && beat_cnt == CW'(k)) w_q[k*VEC_W +: VEC_W] <= data_in;
      end
      for (int c = 0; c < COLS; c++) begin
        if (a_we && beat_cnt == CW'(c)) a_q[c*VEC_W +: VEC_W] <= data_in;
      end
      for (int r = 0; r < ROWS; r++) begin
        if (psum_we && row_cnt == RW'(r)) begin
          psum_q[r*PSUM_W +: PSUM_W] <= row_sum[r];
          sign_q[r]                  <= (row_sum[r] >= PSUM_W'(THRESH));
        end
      end
    end
  end

  assign psum_out  = psum_q;
  assign sign_out  = sign_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_bnn_pe_array_ctrl.sv
// Bench for bnn_pe_array_ctrl at default parameters (3x3, 27-bit words).
module tb_bnn_pe_array_ctrl;
  import bnn_pkg::*;

  localparam int ROWS   = 3;
  localparam int COLS   = 3;
  localparam int VEC_W  = 27;
  localparam int PSUM_W = 7;
  localparam int NW     = ROWS * COLS;
  localparam int W      = ROWS * PSUM_W + ROWS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [VEC_W-1:0]       data_in = '0;
  logic                   reload_in = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [ROWS*PSUM_W-1:0] psum_out;
  logic [ROWS-1:0]        sign_out;
  state_t                 fsm_state;

  bnn_pe_array_ctrl dut (
    .clk_in   (clk),
    .rst_in   (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .reload_in(reload_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .psum_out (psum_out),
    .sign_out (sign_out),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0]     exp_q[$];
  logic [VEC_W-1:0] mw [NW];
  logic [VEC_W-1:0] ma [COLS];
  bit               m_loaded = 0;
  bit               gaps_on = 0;
  int               vectors = 0;
  int               miscompares = 0;

  typedef struct packed {
    logic                   rl;
    logic [NW*VEC_W-1:0]    w;
    logic [COLS*VEC_W-1:0]  a;
    logic [ROWS*PSUM_W-1:0] psum;
    logic [ROWS-1:0]        sign;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [ROWS*PSUM_W-1:0] p;
    logic [ROWS-1:0]        s;
    int                     sum;
    p = '0;
    s = '0;
    for (int r = 0; r < ROWS; r++) begin
      sum = 0;
      for (int c = 0; c < COLS; c++) sum += $countones(~(mw[r*COLS+c] ^ ma[c]));
      p[r*PSUM_W +: PSUM_W] = PSUM_W'(sum);
      s[r] = (sum >= 41);
    end
    return {p, s};
  endfunction

  function automatic logic [NW*VEC_W-1:0] mkw(input logic [VEC_W-1:0] r0,
                                              input logic [VEC_W-1:0] r1,
                                              input logic [VEC_W-1:0] r2);
    return {r2, r2, r2, r1, r1, r1, r0, r0, r0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [VEC_W-1:0] d, input logic rl);
    int budget = 0;
    @(negedge clk);
    if (gaps_on) begin
      while ($urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid  = 1'b1;
    data_in   = d;
    reload_in = rl;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: got in_ready=0 for 200 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic rl, input logic [NW*VEC_W-1:0] w,
                           input logic [COLS*VEC_W-1:0] a,
                           input bit use_exp, input logic [W-1:0] exp);
    bit eff;
    eff = rl || !m_loaded;
    if (eff) begin
      for (int k = 0; k < NW; k++) begin
        send_beat(w[k*VEC_W +: VEC_W], (k == 0) ? rl : 1'($urandom_range(1, 0)));
        mw[k] = w[k*VEC_W +: VEC_W];
      end
      m_loaded = 1;
    end
    for (int c = 0; c < COLS; c++) begin
      send_beat(a[c*VEC_W +: VEC_W], (!eff && c == 0) ? rl : 1'($urandom_range(1, 0)));
      ma[c] = a[c*VEC_W +: VEC_W];
    end
    exp_q.push_back(use_exp ? exp : model_out());
  endtask

  // Wait for results, optionally hold them under backpressure, then handshake.
  task automatic collect(input int hold);
    int           budget = 0;
    logic [W-1:0] snap, expv;
    @(negedge clk);
    while (!out_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL out_timeout: got out_valid=0 for 100 cycles, expected 1");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    snap = {psum_out, sign_out};
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check("result", 32'(snap), 32'(expv));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      data_in  = VEC_W'($urandom);
      @(negedge clk);
      check("bp_hold", 32'({psum_out, sign_out}), 32'(snap));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("post_hs_state", 32'(fsm_state), 32'(IDLE));
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_hold", 32'({psum_out, sign_out}), 32'(snap));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_psum"}, 32'(psum_out), 32'd0);
    check({tag, "_sign"}, 32'(sign_out), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [NW*VEC_W-1:0]   rw;
    logic [COLS*VEC_W-1:0] ra;
    logic [VEC_W-1:0]      ones, alt;
    ones = 27'h7FFFFFF;
    alt  = 27'h5555555;

    // Stimulus table: {reload, weights, activations, expected psums {r2,r1,r0}, expected signs}.
    tbl[0] = '{1'b0, mkw(ones, ones, ones), {ones, ones, ones}, {7'd81, 7'd81, 7'd81}, 3'b111};
    tbl[1] = '{1'b1, mkw(ones, ones, ones), {27'd0, 27'd0, 27'd0}, {7'd0, 7'd0, 7'd0}, 3'b000};
    tbl[2] = '{1'b1, mkw(ones, alt, ones), {ones, ones, ones}, {7'd81, 7'd42, 7'd81}, 3'b111};
    tbl[3] = '{1'b0, '0, {27'd0, 27'd0, 27'd0}, {7'd0, 7'd39, 7'd0}, 3'b000};
    tbl[4] = '{1'b0, '0, {ones, 27'd0, ones}, {7'd54, 7'd41, 7'd54}, 3'b111};
    tbl[5] = '{1'b1, mkw(27'd0, ones, alt), {ones, ones, ones}, {7'd42, 7'd81, 7'd0}, 3'b110};

    for (int k = 0; k < NW; k++) mw[k] = '0;
    for (int c = 0; c < COLS; c++) ma[c] = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // First frame after reset with reload_in=0 must still load 9 weights;
    // also time the row updates against the last activation edge E.
    run_frame(tbl[0].rl, tbl[0].w, tbl[0].a, 1, {tbl[0].psum, tbl[0].sign});
    @(posedge clk); #1;
    check("lat_row0_at_e1", 32'(psum_out[6:0]), 32'd81);
    check("lat_row1_at_e1", 32'(psum_out[13:7]), 32'd0);
    check("lat_valid_at_e1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid_at_e2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid_at_e3", 32'(out_valid), 32'd1);
    collect(0);

    // Remaining table entries; the first reuse frame is held under backpressure.
    for (int i = 1; i < 6; i++) begin
      run_frame(tbl[i].rl, tbl[i].w, tbl[i].a, 1, {tbl[i].psum, tbl[i].sign});
      collect((i == 3) ? 5 : 0);
    end

    // Random frames with random in_valid gaps, checked against the model.
    gaps_on = 1;
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < NW; k++) rw[k*VEC_W +: VEC_W] = VEC_W'($urandom);
      for (int c = 0; c < COLS; c++) ra[c*VEC_W +: VEC_W] = VEC_W'($urandom);
      run_frame(1'($urandom_range(1, 0)), rw, ra, 0, '0);
      collect($urandom_range(2, 0));
    end
    gaps_on = 0;

    // Known nonzero results, then reset during weight beat 4 of a reload frame.
    run_frame(1'b1, mkw(ones, ones, ones), {ones, ones, ones}, 0, '0);
    collect(0);
    for (int k = 0; k < 4; k++) send_beat(ones, (k == 0) ? 1'b1 : 1'b0);
    @(negedge clk);
    in_valid  = 1'b1;
    data_in   = ones;
    reload_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    m_loaded = 0;
    for (int k = 0; k < NW; k++) mw[k] = '0;
    for (int c = 0; c < COLS; c++) ma[c] = '0;
    exp_q.delete();

    // reload_in=0 after reset must still take 9 weights.
    run_frame(1'b0, mkw(alt, 27'd0, ones), {ones, ones, ones}, 1,
              {7'd81, 7'd0, 7'd42, 3'b101});
    collect(0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bnn_pe_array_ctrl.md
# bnn_pe_array_ctrl

Parametrised ROWS×COLS weight-stationary binary (XNOR-popcount) PE array with its own frame controller and valid/ready streaming. It is the generalised successor of the fixed 3×3, 27-bit kernel array. Weights and activations arrive time-multiplexed on one input bus. Per-row popcount sums and binarised sign bits leave through a held output handshake. A frame may reuse resident weights, which skips the weight-load phase.

## Interface
- ROWS, 3, number of PE rows (output channels per frame)
- COLS, 3, PEs per row (activation words per frame)
- VEC_W, 27, bits per weight/activation word
- PSUM_W, $clog2(COLS*VEC_W+1), row-sum width (7 at defaults)
- THRESH, (COLS*VEC_W+1)/2, binarisation threshold (41 at defaults)
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-low
- in_valid  in  1  data_in beat valid
- in_ready  out  1  controller accepts a beat
- data_in  in  VEC_W  weight or activation word
- reload_in  in  1  sampled on the first beat of a frame: 1 = frame starts with ROWS*COLS weight beats
- out_valid  out  1  results held valid
- out_ready  in  1  downstream accepts results
- psum_out  out  ROWS*PSUM_W  row sums; row r at [r*PSUM_W +: PSUM_W]
- sign_out  out  ROWS  bit r = (psum row r >= THRESH)

## Operation
- A beat is accepted on a rising edge with in_valid && in_ready.
- States:
  - IDLE. in_ready=1. The first accepted beat starts a frame. reload_eff = reload_in || !weights_loaded.
    - reload_eff=1: the beat is weight 0, next state LOAD_W.
    - reload_eff=0: the beat is activation 0, next state LOAD_A. If COLS=1, next state is COMPUTE.
  - LOAD_W. in_ready=1.
    - Weight beat k (0..ROWS*COLS-1) is stored at row k/COLS, column k%COLS.
    - After beat ROWS*COLS-1, weights_loaded is set and next state is LOAD_A.
  - LOAD_A. in_ready=1. Activation beat c (0..COLS-1) is stored at column c. After beat COLS-1, next state is COMPUTE.
  - COMPUTE. in_ready=0. Lasts exactly ROWS cycles. On COMPUTE cycle j, the row-j sum register is written, then the next state is OUT.
  - OUT. out_valid=1 and in_ready=0. Leaves on out_valid && out_ready to IDLE.
- Row sum: psum[r] = Σc popcount(~(w[r][c] ^ a[c])), computed at full width PSUM_W, so overflow is impossible.
- Weights persist across frames until overwritten or reset.
- Activations are overwritten each frame.
- psum_out and sign_out keep their values after the handshake until rewritten in the next COMPUTE.
- Gaps: in_valid low for any number of cycles mid-phase stalls the beat counter. There is no timeout.
- reload_in is ignored on every beat except the first of a frame.

## Timing
- Reset (async assert, sync release) drives the following:
  - state=IDLE, in_ready=1, out_valid=0.
  - psum_out=0, sign_out=0.
  - All weights and activations = 0.
  - weights_loaded=0, beat counters=0.
- Reset mid-frame aborts the frame. The next frame is forced to reload_eff=1.
- Latency:
  - Call the edge that accepts the last activation beat E.
  - Row j's sum updates at edge E+1+j.
  - out_valid is high from edge E+ROWS.
- Throughput:
  - Reuse frame: COLS+ROWS cycles + 1 handshake cycle minimum.
  - Reload frame: an additional ROWS*COLS cycles.
- No input is accepted in the same cycle as the output handshake.
- Minimum gap is one IDLE cycle with in_ready=1 after OUT.
- out_ready may be high before out_valid. The handshake completes on the first OUT cycle.

## Structure
- Shared package bnn_pkg:
  - State enum (IDLE, LOAD_W, LOAD_A, COMPUTE, OUT).
  - Constant functions for PSUM_W and the default THRESH.
- Sub-module bnn_pe_row:
  - Inputs: COLS weights and COLS activations.
  - Output: combinational PSUM_W popcount sum.
  - Instantiated ROWS times.
- The top level holds the FSM, beat counters, weight/activation storage, and the psum/sign registers.

## Test plan
- Reload frame, all weights 1s, all activations 1s (defaults) -> every psum=81, sign_out=3'b111. out_valid rises 3 edges after the last activation beat.
- Weights 1s, activations 0s -> psum=0, sign=000. Row 1 weights = 0x5555555 (bits 0..26 alternating), activations 0x7FFFFFF -> row1 psum=42, sign bit1=1.
- Reuse frame (reload_in=0) after a reload frame: only 3 beats accepted, with the previous weights applied. Also, reload_in=0 as the first frame after reset -> treated as reload, so 9 weight beats are expected.
- Backpressure: out_ready low 5 cycles -> psum/sign stable, in_ready=0 throughout, in_valid beats ignored. Release -> IDLE next cycle.
- Random in_valid gaps (≈50% duty) over 20 frames: results match the reference model and are independent of gap pattern.
- Assert rst_in during LOAD_W beat 4 -> all outputs 0 immediately. The next frame with reload_in=0 still loads 9 weights.
